fir_datapath: RTL and testbench
===============================

// Module: fir_datapath
// PURPOSE
//  Register-file datapath consuming the FIR controller's op/src1/src2/dest each cycle.
//  Loads samples and coefficients, shifts the sample window and accumulates signed sums.
//  Reports signed overflow back to the controller in the same cycle.
//  Exposes register 0 (the accumulator) as the filter result.
// PARAMETERS
//  DATA_W   16   register/sample width, signed two's complement
//  NREGS    16   register count; index NREGS-1 (4'hF) is the NONE/external pseudo-register
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  n_reset      in   1       asynchronous active-low reset
//  op           in   2       operation: 00 NOP, 01 SUB, 10 COPY, 11 ADD
//  src1         in   4       first operand register index
//  src2         in   4       second operand register index
//  dest         in   4       destination register index
//  data_in      in   DATA_W  external sample; read whenever a source index is 4'hF
//  overflow     out  1       combinational signed-overflow flag for the current op
//  outreg_data  out  DATA_W  registered copy of reg[0]
// BEHAVIOUR
//  - Reset: all regs 0, outreg_data 0, overflow 0 (no op in flight).
//  - Operand read: rd(i) = (i==4'hF) ? data_in : reg[i]. Reads are combinational.
//  - Operations, written on the rising edge:
//    COPY  reg[dest] <= rd(src1)
//    ADD   reg[dest] <= rd(src1)+rd(src2)
//    SUB   reg[dest] <= rd(src1)-rd(src2)
//    NOP   no write
//  - dest==4'hF: write discarded, overflow still computed.
//  - Read-before-write: a source equal to dest returns the old value in that cycle.
//    The new value is visible next cycle (e.g. src2=0, dest=0 accumulates).
//  - Arithmetic: DATA_W-bit wrap, no widening.
//    ADD overflow = operand signs equal AND result sign differs.
//    SUB overflow = operand signs differ AND result sign differs from src1.
//    overflow=0 for NOP/COPY.
//  - overflow is purely combinational from op/src/data_in/regs, valid in the same cycle.
//    The controller samples it into its next-state decision.
//  - outreg_data <= value written to reg[0] in the cycle reg[0] is written (one-cycle latency).
//    It holds otherwise.
//  - On overflow, the wrapped result is still written (unless SAT is enabled).
//    Controller error recovery is not the datapath's concern.
//  - Reset mid-operation: the asynchronous clear wins; a pending write is lost.
//  - Unknown/X op is treated as NOP.
// CONFIGURATION
//  FIR_DP_SAT_EN
//    defined:   ADD/SUB write a saturated result on overflow
//               (0x7FFF positive, 0x8000 negative); overflow flag still asserted.
//    undefined: wrapped result written.
// STRUCTURE
//  - Package fir_pkg:
//    op_t enum {OP_NOP=2'b00, OP_SUB=2'b01, OP_COPY=2'b10, OP_ADD=2'b11}
//    REG_NONE=4'hF, DATA_W, NREGS.
//  - Sub-module fir_reg_file (NREGS x DATA_W):
//    two async read ports, one sync write port, async reset; reg[NREGS-1] unimplemented.
//  - ALU, overflow and saturation logic live in fir_datapath.
// TESTING
//  - Reset: assert n_reset=0 mid-write -> all regs, outreg_data = 0 immediately; overflow=0.
//  - COPY ext: data_in=0x1234, op=COPY, src1=F, dest=5
//    -> reg5=0x1234 next cycle; outreg_data unchanged.
//  - Accumulate: reg1=0x0010, reg2=0x0020, reg3=0x0005
//    -> ADD 1,2 -> 0; then ADD 3,0 -> 0 -> reg0 = 0x0035, outreg_data = 0x0035 one cycle after.
//  - Overflow: reg1=0x7FFF, reg2=0x0001, ADD -> overflow=1 same cycle
//    -> reg0=0x8000 (SAT off) or 0x7FFF (SAT on).
//  - SUB underflow: reg1=0x8000, reg2=0x0001, SUB -> overflow=1
//    -> reg0=0x7FFF (SAT off) or 0x8000 (SAT on).
//  - Discard/NOP: op=ADD with dest=F, and op=NOP with dest=3 -> no register changes;
//    overflow is still computed for the ADD.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and sizes for the FIR datapath register file and ALU.
// Optional feature macro: FIR_DP_SAT_EN (saturate ADD/SUB results on overflow).
package fir_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREGS  = 16;
  localparam int unsigned IDX_W  = 4;

  // Index NREGS-1 selects the external sample on reads and discards writes
  localparam logic [IDX_W-1:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_SUB  = 2'b01,
    OP_COPY = 2'b10,
    OP_ADD  = 2'b11
  } op_t;

  // Saturation bound chosen by the sign of the first operand: overflow can
  // only push the result past the bound on that operand's side
  function automatic logic [DATA_W-1:0] sat_value(input logic neg);
    logic [DATA_W-1:0] v;
    if (neg) v = {1'b1, {(DATA_W-1){1'b0}}};
    else     v = {1'b0, {(DATA_W-1){1'b1}}};
    return v;
  endfunction

endpackage

// File: rtl/fir_reg_file.sv
// Register file for the FIR datapath: NREGS-1 implemented entries of DATA_W bits.
// Ports:
//   clk, n_reset            clock, asynchronous active-low reset
//   rd1_idx / rd1_data_c    first combinational read port
//   rd2_idx / rd2_data_c    second combinational read port
//   wr_en, wr_idx, wr_data  synchronous write port
// Index REG_NONE has no storage: it reads as zero and writes to it are dropped.
module fir_reg_file
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              n_reset,
  input  logic [IDX_W-1:0]  rd1_idx,
  output logic [DATA_W-1:0] rd1_data_c,
  input  logic [IDX_W-1:0]  rd2_idx,
  output logic [DATA_W-1:0] rd2_data_c,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int unsigned NIMPL = NREGS - 1;

  logic [DATA_W-1:0] mem_q [NIMPL];
  logic [DATA_W-1:0] mem_d [NIMPL];

  // Read ports: a one-hot style compare avoids indexing past the last entry
  always_comb begin
    rd1_data_c = '0;
    rd2_data_c = '0;
    for (int unsigned i = 0; i < NIMPL; i++) begin
      if (rd1_idx == IDX_W'(i)) rd1_data_c = mem_q[i];
      if (rd2_idx == IDX_W'(i)) rd2_data_c = mem_q[i];
    end
  end

  // Write port: REG_NONE matches no entry, so that write vanishes
  always_comb begin
    for (int unsigned i = 0; i < NIMPL; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (wr_idx == IDX_W'(i))) mem_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int unsigned i = 0; i < NIMPL; i++) mem_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NIMPL; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/fir_datapath.sv
// FIR datapath: executes the controller's op on the register file each cycle,
// flags signed overflow combinationally and exposes reg[0] as the result.
// Ports:
//   clk, n_reset        clock, asynchronous active-low reset
//   op                  00 NOP, 01 SUB, 10 COPY, 11 ADD (unknown -> NOP)
//   src1, src2, dest    register indices; 4'hF reads data_in / discards write
//   data_in             external sample
//   overflow            combinational signed overflow of the current op
//   outreg_data         registered copy of the last value written to reg[0]
// Optional feature: define FIR_DP_SAT_EN to saturate ADD/SUB results on overflow.
module fir_datapath
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              n_reset,
  input  logic [1:0]        op,
  input  logic [IDX_W-1:0]  src1,
  input  logic [IDX_W-1:0]  src2,
  input  logic [IDX_W-1:0]  dest,
  input  logic [DATA_W-1:0] data_in,
  output logic              overflow,
  output logic [DATA_W-1:0] outreg_data
);

  localparam int unsigned MSB = DATA_W - 1;

  op_t               op_e;
  logic [DATA_W-1:0] rf_rd1_c, rf_rd2_c;
  logic [DATA_W-1:0] rd1_c, rd2_c;
  logic [DATA_W-1:0] sum_c, diff_c;
  logic              ovf_add_c, ovf_sub_c;
  logic              wr_en_c;
  logic [DATA_W-1:0] wr_data_c;
  logic [DATA_W-1:0] outreg_d, outreg_q;

  assign op_e = op_t'(op);

  fir_reg_file u_reg_file (
    .clk        (clk),
    .n_reset    (n_reset),
    .rd1_idx    (src1),
    .rd1_data_c (rf_rd1_c),
    .rd2_idx    (src2),
    .rd2_data_c (rf_rd2_c),
    .wr_en      (wr_en_c),
    .wr_idx     (dest),
    .wr_data    (wr_data_c)
  );

  // Operand select: pseudo-register reads the external sample
  always_comb begin
    rd1_c = (src1 == REG_NONE) ? data_in : rf_rd1_c;
    rd2_c = (src2 == REG_NONE) ? data_in : rf_rd2_c;
  end

  // Wrapping arithmetic and signed overflow detection
  always_comb begin
    sum_c     = rd1_c + rd2_c;
    diff_c    = rd1_c - rd2_c;
    ovf_add_c = (rd1_c[MSB] == rd2_c[MSB]) && (sum_c[MSB]  != rd1_c[MSB]);
    ovf_sub_c = (rd1_c[MSB] != rd2_c[MSB]) && (diff_c[MSB] != rd1_c[MSB]);
  end

  // Op decode: anything not a known op (including X) falls to the NOP default
  always_comb begin
    wr_en_c   = 1'b0;
    wr_data_c = '0;
    overflow  = 1'b0;
    case (op_e)
      OP_ADD: begin
        wr_en_c   = 1'b1;
        overflow  = ovf_add_c;
        wr_data_c = sum_c;
`ifdef FIR_DP_SAT_EN
        if (ovf_add_c) wr_data_c = sat_value(rd1_c[MSB]);
`endif
      end
      OP_SUB: begin
        wr_en_c   = 1'b1;
        overflow  = ovf_sub_c;
        wr_data_c = diff_c;
`ifdef FIR_DP_SAT_EN
        if (ovf_sub_c) wr_data_c = sat_value(rd1_c[MSB]);
`endif
      end
      OP_COPY: begin
        wr_en_c   = 1'b1;
        wr_data_c = rd1_c;
      end
      default: ;
    endcase
  end

  // Result register tracks writes to reg[0] only
  always_comb begin
    outreg_d = outreg_q;
    if (wr_en_c && (dest == IDX_W'(0))) outreg_d = wr_data_c;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) outreg_q <= '0;
    else          outreg_q <= outreg_d;
  end

  assign outreg_data = outreg_q;

endmodule

// File: tb/tb_fir_datapath.sv
// Directed self-checking bench for fir_datapath.
// Register contents are observed by copying them into reg[0] and reading outreg_data.
module tb_fir_datapath;
  import fir_pkg::*;

  logic        clk;
  logic        n_reset;
  logic [1:0]  op;
  logic [3:0]  src1, src2, dest;
  logic [15:0] data_in;
  logic        overflow;
  logic [15:0] outreg_data;

  int unsigned n_cmp;
  int unsigned n_err;

`ifdef FIR_DP_SAT_EN
  localparam logic [15:0] EXP_ADD_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_SUB_OVF = 16'h8000;
`else
  localparam logic [15:0] EXP_ADD_OVF = 16'h8000;
  localparam logic [15:0] EXP_SUB_OVF = 16'h7FFF;
`endif

  fir_datapath dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .op          (op),
    .src1        (src1),
    .src2        (src2),
    .dest        (dest),
    .data_in     (data_in),
    .overflow    (overflow),
    .outreg_data (outreg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Drive one op just after a rising edge, sample overflow mid-cycle, then
  // let the edge commit it and return 1 time unit after that edge
  task automatic do_op(input logic [1:0] o, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] d, input logic [15:0] din, output logic ovf);
    op = o; src1 = s1; src2 = s2; dest = d; data_in = din;
    #1 ovf = overflow;
    @(posedge clk);
    #1;
    op = OP_NOP; src1 = 4'h0; src2 = 4'h0; dest = 4'h0; data_in = 16'h0;
  endtask

  task automatic load(input logic [3:0] idx, input logic [15:0] val);
    logic o;
    do_op(OP_COPY, REG_NONE, REG_NONE, idx, val, o);
  endtask

  task automatic peek(input string tag, input logic [3:0] idx, input logic [15:0] exp);
    logic o;
    do_op(OP_COPY, idx, REG_NONE, 4'h0, 16'h0, o);
    check(tag, outreg_data, exp);
  endtask

  initial begin
    logic ovf;
    n_cmp = 0; n_err = 0;
    n_reset = 1'b0;
    op = OP_NOP; src1 = 4'h0; src2 = 4'h0; dest = 4'h0; data_in = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outreg", outreg_data, 16'h0000);
    check("rst_ovf", 16'(overflow), 16'h0000);
    n_reset = 1'b1;
    @(posedge clk); #1;

    peek("rst_r5", 4'h5, 16'h0000);
    peek("rst_r1", 4'h1, 16'h0000);

    // COPY external into reg5 leaves outreg alone
    load(4'h0, 16'hAAAA);
    check("copy_r0", outreg_data, 16'hAAAA);
    do_op(OP_COPY, REG_NONE, REG_NONE, 4'h5, 16'h1234, ovf);
    check("copy_ext_ovf", 16'(ovf), 16'h0000);
    check("copy_ext_outreg", outreg_data, 16'hAAAA);
    peek("copy_ext_r5", 4'h5, 16'h1234);

    // Accumulate: reads of reg0 see the old value in the same cycle
    load(4'h1, 16'h0010);
    load(4'h2, 16'h0020);
    load(4'h3, 16'h0005);
    do_op(OP_ADD, 4'h1, 4'h2, 4'h0, 16'h0, ovf);
    check("acc1_ovf", 16'(ovf), 16'h0000);
    check("acc1", outreg_data, 16'h0030);
    do_op(OP_ADD, 4'h3, 4'h0, 4'h0, 16'h0, ovf);
    check("acc2", outreg_data, 16'h0035);

    // Positive overflow on ADD
    load(4'h1, 16'h7FFF);
    load(4'h2, 16'h0001);
    do_op(OP_ADD, 4'h1, 4'h2, 4'h0, 16'h0, ovf);
    check("add_ovf", 16'(ovf), 16'h0001);
    check("add_ovf_val", outreg_data, EXP_ADD_OVF);

    // Negative overflow on SUB
    load(4'h1, 16'h8000);
    do_op(OP_SUB, 4'h1, 4'h2, 4'h0, 16'h0, ovf);
    check("sub_ovf", 16'(ovf), 16'h0001);
    check("sub_ovf_val", outreg_data, EXP_SUB_OVF);

    // SUB to a negative result without overflow, operand from data_in
    load(4'h4, 16'h0005);
    do_op(OP_SUB, 4'h4, REG_NONE, 4'h0, 16'h0007, ovf);
    check("sub_neg_ovf", 16'(ovf), 16'h0000);
    check("sub_neg_val", outreg_data, 16'hFFFE);

    // ADD with dest=F: overflow reported, nothing written
    load(4'h1, 16'h7FFF);
    do_op(OP_ADD, 4'h1, 4'h2, REG_NONE, 16'h0, ovf);
    check("discard_ovf", 16'(ovf), 16'h0001);
    check("discard_outreg", outreg_data, 16'hFFFE);

    // NOP with dest=3 leaves reg3
    do_op(OP_NOP, 4'h1, 4'h2, 4'h3, 16'h0, ovf);
    check("nop_ovf", 16'(ovf), 16'h0000);
    check("nop_outreg", outreg_data, 16'hFFFE);
    peek("nop_r3", 4'h3, 16'h0005);
    peek("discard_r1", 4'h1, 16'h7FFF);
    peek("discard_r2", 4'h2, 16'h0001);

    // COPY of a negative extreme never flags overflow
    do_op(OP_COPY, REG_NONE, REG_NONE, 4'h6, 16'h8000, ovf);
    check("copy_neg_ovf", 16'(ovf), 16'h0000);
    peek("copy_neg_r6", 4'h6, 16'h8000);

    // Unknown op behaves as NOP
    do_op(2'bxx, 4'h1, 4'h2, 4'h3, 16'h0, ovf);
    peek("xop_r3", 4'h3, 16'h0005);

    // Reset in the middle of a pending write to reg0
    load(4'h5, 16'h1234);
    op = OP_COPY; src1 = REG_NONE; src2 = REG_NONE; dest = 4'h0; data_in = 16'h5555;
    #2 n_reset = 1'b0;
    #1;
    check("midrst_outreg", outreg_data, 16'h0000);
    check("midrst_ovf", 16'(overflow), 16'h0000);
    @(posedge clk); #1;
    check("midrst_hold", outreg_data, 16'h0000);
    op = OP_NOP; src1 = 4'h0; dest = 4'h0; data_in = 16'h0;
    n_reset = 1'b1;
    @(posedge clk); #1;
    peek("midrst_r5", 4'h5, 16'h0000);
    peek("midrst_r0", 4'h0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
